// File: rtl/sseg_to_bcd.sv
// sseg_to_bcd
//   Recovers BCD digits from a multiplexed, active-low seven-segment display
//   bus. The an/sseg pair is sampled every cycle; a digit is captured once its
//   sample has stayed unchanged for long enough to be trusted, which filters
//   out ghosting while the display driver switches digits.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high reset
//   an[3:0]      : digit enables, active low (an[i]=0 selects digit i)
//   sseg[7:0]    : segments, active low; [6:0] = a..g, [7] = decimal point
//   bcd[15:0]    : captured digits, digit i at bcd[4i+3:4i] (F = unrecognised)
//   dp[3:0]      : captured decimal points, active high
//   err[3:0]     : digit i was captured with an unrecognised pattern
//   frame_valid  : one-cycle pulse when all four digits have been captured
//   err_cnt[7:0] : saturating count of unrecognised captures
module sseg_to_bcd #(
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] bcd,
  output logic [3:0]  dp,
  output logic [3:0]  err,
  output logic        frame_valid,
  output logic [7:0]  err_cnt
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);
  localparam logic [3:0] CNT_CAP = 4'(STABLE_CNT - 2);

  logic [3:0]  anSample_q, anLast_q;
  logic [7:0]  ssegSample_q, ssegLast_q;
  logic [3:0]  stableCnt_q, stableCnt_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  err_q, err_d;
  logic [7:0]  errCnt_q, errCnt_d;
  logic [3:0]  seen_q, seen_d;
  logic        frameValid_q, frameValid_d;

  logic        sampleLegal;
  logic        sampleSame;
  logic        capture;
  logic [1:0]  digitIdx;
  logic [3:0]  digitMask;
  logic [3:0]  seenNext;
  logic        segValid;
  logic [3:0]  segValue;

  // Decode the one-hot-low digit enable; anything other than exactly one low
  // bit (blank or several digits driven) is not a usable sample.
  always_comb begin
    sampleLegal = 1'b1;
    digitIdx    = 2'd0;
    case (anSample_q)
      4'b1110: digitIdx = 2'd0;
      4'b1101: digitIdx = 2'd1;
      4'b1011: digitIdx = 2'd2;
      4'b0111: digitIdx = 2'd3;
      default: sampleLegal = 1'b0;
    endcase
    digitMask = 4'b0001 << digitIdx;
  end

  // Segment pattern to BCD; unknown patterns are flagged and read as F.
  always_comb begin
    segValid = 1'b1;
    segValue = 4'hF;
    case (ssegSample_q[6:0])
      7'b0000001: segValue = 4'd0;
      7'b1001111: segValue = 4'd1;
      7'b0010010: segValue = 4'd2;
      7'b0000110: segValue = 4'd3;
      7'b1001100: segValue = 4'd4;
      7'b0100100: segValue = 4'd5;
      7'b0100000: segValue = 4'd6;
      7'b0001111: segValue = 4'd7;
      7'b0000000: segValue = 4'd8;
      7'b0000100: segValue = 4'd9;
      default:    segValid = 1'b0;
    endcase
  end

  // The stability counter compares the current sample with the one before it.
  // Capturing on the transition into STABLE_CNT-1 (not on "equals") and
  // saturating above it means a held digit is captured exactly once.
  always_comb begin
    sampleSame  = (anSample_q == anLast_q) && (ssegSample_q == ssegLast_q);
    stableCnt_d = stableCnt_q;
    capture     = 1'b0;
    if (!sampleLegal || !sampleSame) begin
      stableCnt_d = 4'd0;
    end else begin
      if (stableCnt_q < CNT_MAX) begin
        stableCnt_d = stableCnt_q + 4'd1;
      end
      capture = (stableCnt_q == CNT_CAP);
    end
  end

  // Capture update: overwrite the selected digit, track which digits have
  // been seen, and close the frame when the last missing digit arrives.
  always_comb begin
    bcd_d        = bcd_q;
    dp_d         = dp_q;
    err_d        = err_q;
    errCnt_d     = errCnt_q;
    seen_d       = seen_q;
    frameValid_d = 1'b0;
    seenNext     = seen_q | digitMask;
    if (capture) begin
      bcd_d[{digitIdx, 2'b00} +: 4] = segValue;
      dp_d[digitIdx]                = ~ssegSample_q[7];
      err_d[digitIdx]               = ~segValid;
      if (!segValid && (errCnt_q != 8'hFF)) begin
        errCnt_d = errCnt_q + 8'd1;
      end
      if (seenNext == 4'b1111) begin
        frameValid_d = 1'b1;
        seen_d       = 4'b0000;
      end else begin
        seen_d = seenNext;
      end
    end
  end

  // All state, including the sample stage, is cleared by reset so that no
  // pre-reset sample can contribute to a later capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      anSample_q   <= 4'h0;
      ssegSample_q <= 8'h00;
      anLast_q     <= 4'h0;
      ssegLast_q   <= 8'h00;
      stableCnt_q  <= 4'd0;
      bcd_q        <= 16'h0000;
      dp_q         <= 4'h0;
      err_q        <= 4'h0;
      errCnt_q     <= 8'h00;
      seen_q       <= 4'h0;
      frameValid_q <= 1'b0;
    end else begin
      anSample_q   <= an;
      ssegSample_q <= sseg;
      anLast_q     <= anSample_q;
      ssegLast_q   <= ssegSample_q;
      stableCnt_q  <= stableCnt_d;
      bcd_q        <= bcd_d;
      dp_q         <= dp_d;
      err_q        <= err_d;
      errCnt_q     <= errCnt_d;
      seen_q       <= seen_d;
      frameValid_q <= frameValid_d;
    end
  end

  assign bcd         = bcd_q;
  assign dp          = dp_q;
  assign err         = err_q;
  assign err_cnt     = errCnt_q;
  assign frame_valid = frameValid_q;

endmodule
